multicycle_ctrl: RTL and testbench

Control sequencer for the multi-cycle variant of the processor datapath. It drives a shared instruction/data memory port, the ALU operand muxes, the immediate extender mode, the PC/IR/register-file write enables and the write-back mux, one instruction at a time. Memory access uses a req/ready handshake with arbitrary wait states. The block sits beside the datapath and reads the instruction register and the registered Z flag.

---
 rtl/mctrl_pkg.sv | 47 ++++
 rtl/mctrl_cond_check.sv | 20 ++
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// Contents: state enum, op/cond codes, ALU-B and extender encodings,
// and the packed control-word struct driven by the output decoder.
package mctrl_pkg;

    localparam int unsigned SRCB_W = 2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;

    localparam logic [SRCB_W-1:0] SRCB_REG  = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic EXT_IMM12 = 1'b0;
    localparam logic EXT_BR24  = 1'b1;

    // One control word per cycle; every field is a datapath control line.
    typedef struct packed {
        logic              mem_req;
        logic              mem_we;
        logic              addr_sel;
        logic              ir_we;
        logic              pc_we;
        logic              reg_we;
        logic              flags_we;
        logic              pc_src;
        logic              alu_src_a;
        logic [SRCB_W-1:0] alu_src_b;
        logic              ext_sel;
        logic              wb_sel;
        logic              illegal;
    } ctrl_t;

endpackage

// File: rtl/mctrl_cond_check.sv
// Condition evaluator: EQ needs Z set, NE needs Z clear, all other codes pass.
// Ports: cond[3:0] (instruction cond field), zflag (registered Z), pass.
module mctrl_cond_check
    import mctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       zflag,
    output logic       pass
);

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = zflag;
            COND_NE: pass = ~zflag;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle processor control sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Inputs : clk, rst_n (sync, active-low), instr[31:0], zflag, mem_ready.
// Outputs: mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, flags_we, pc_src,
//          alu_src_a, alu_src_b[1:0], ext_sel, wb_sel, illegal, state[2:0].
// Controls decode combinationally from the state register and instr, and are
// forced to zero while rst_n is low.
// Build option MCTRL_PERF_EN adds cycle_cnt[31:0] and retired_cnt[31:0].
module multicycle_ctrl
    import mctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zflag,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        flags_we,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_sel,
    output logic        wb_sel,
    output logic        illegal,
    output logic [2:0]  state
`ifdef MCTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    logic [3:0] cond;
    logic [1:0] op;
    logic       imm_bit;
    logic       load_bit;
    logic       cond_pass;
    logic       unused_instr_bits;

    assign cond     = instr[31:28];
    assign op       = instr[27:26];
    assign imm_bit  = instr[25];
    assign load_bit = instr[20];
    assign unused_instr_bits = ^{instr[24:21], instr[19:0]};

    mctrl_cond_check u_cond (
        .cond  (cond),
        .zflag (zflag),
        .pass  (cond_pass)
    );

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (op)
                    OP_DP:   state_d = cond_pass ? ST_WB  : ST_FETCH;
                    OP_MEM:  state_d = cond_pass ? ST_MEM : ST_FETCH;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM:    if (mem_ready) state_d = load_bit ? ST_WB : ST_FETCH;
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Output decode; everything held at zero while in reset
    always_comb begin
        ctrl = '0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    ctrl.mem_req   = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    // IR and PC+4 latch in the cycle memory completes
                    ctrl.ir_we     = mem_ready;
                    ctrl.pc_we     = mem_ready;
                end
                ST_EXEC: begin
                    case (op)
                        OP_DP: begin
                            ctrl.alu_src_a = 1'b1;
                            ctrl.alu_src_b = imm_bit ? SRCB_IMM : SRCB_REG;
                            ctrl.ext_sel   = EXT_IMM12;
                            ctrl.flags_we  = cond_pass;
                        end
                        OP_MEM: begin
                            ctrl.alu_src_a = 1'b1;
                            ctrl.alu_src_b = SRCB_IMM;
                            ctrl.ext_sel   = EXT_IMM12;
                        end
                        OP_BR: begin
                            // PC already holds fetch address + 4
                            ctrl.alu_src_b = SRCB_IMM;
                            ctrl.ext_sel   = EXT_BR24;
                            ctrl.pc_src    = 1'b1;
                            ctrl.pc_we     = cond_pass;
                        end
                        default: ctrl.illegal = 1'b1;
                    endcase
                end
                ST_MEM: begin
                    ctrl.mem_req  = 1'b1;
                    ctrl.addr_sel = 1'b1;
                    ctrl.mem_we   = ~load_bit;
                end
                ST_WB: begin
                    ctrl.reg_we = 1'b1;
                    ctrl.wb_sel = (op == OP_MEM) ? load_bit : 1'b0;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign mem_req   = ctrl.mem_req;
    assign mem_we    = ctrl.mem_we;
    assign addr_sel  = ctrl.addr_sel;
    assign ir_we     = ctrl.ir_we;
    assign pc_we     = ctrl.pc_we;
    assign reg_we    = ctrl.reg_we;
    assign flags_we  = ctrl.flags_we;
    assign pc_src    = ctrl.pc_src;
    assign alu_src_a = ctrl.alu_src_a;
    assign alu_src_b = ctrl.alu_src_b;
    assign ext_sel   = ctrl.ext_sel;
    assign wb_sel    = ctrl.wb_sel;
    assign illegal   = ctrl.illegal;
    assign state     = rst_n ? 3'(state_q) : 3'(ST_FETCH);

`ifdef MCTRL_PERF_EN
    logic retire;

    // An instruction retires whenever the sequencer returns to FETCH
    assign retire = ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB))
                    && (state_d == ST_FETCH);

    // Performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Each step drives inputs just after a rising edge, lets them settle, checks
// the state and the full control word, then advances one clock.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zflag;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, flags_we;
    logic        pc_src, alu_src_a, ext_sel, wb_sel, illegal;
    logic [1:0]  alu_src_b;
    logic [2:0]  state;
`ifdef MCTRL_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .zflag     (zflag),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .reg_we    (reg_we),
        .flags_we  (flags_we),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ext_sel   (ext_sel),
        .wb_sel    (wb_sel),
        .illegal   (illegal),
        .state     (state)
`ifdef MCTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    logic [13:0] outs;
    assign outs = {mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, flags_we,
                   pc_src, alu_src_a, alu_src_b, ext_sel, wb_sel, illegal};

    // Packs hand-written expected control lines in the same order as outs
    function automatic logic [13:0] ov(input logic mreq, input logic mwe, input logic asel,
                                       input logic irwe, input logic pcwe, input logic regwe,
                                       input logic flwe, input logic psrc, input logic asa,
                                       input logic [1:0] asb, input logic ext, input logic wb,
                                       input logic ill);
        return {mreq, mwe, asel, irwe, pcwe, regwe, flwe, psrc, asa, asb, ext, wb, ill};
    endfunction

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] es, input logic [13:0] eo);
        #2;
        chk({tag, ".state"}, 32'(state), 32'(es));
        chk({tag, ".ctrl"},  32'(outs),  32'(eo));
        @(posedge clk);
        #1;
    endtask

    logic [13:0] v_zero, v_f0, v_f1, v_dp_e, v_dp_fail, v_mem_e, v_ld_m, v_st_m;
    logic [13:0] v_wb_alu, v_wb_ld, v_br_fail, v_br_pass, v_ill;

    initial begin
        v_zero    = '0;
        v_f0      = ov(1,0,0,0,0,0,0,0,0,2'b10,0,0,0);
        v_f1      = ov(1,0,0,1,1,0,0,0,0,2'b10,0,0,0);
        v_dp_e    = ov(0,0,0,0,0,0,1,0,1,2'b01,0,0,0);
        v_dp_fail = ov(0,0,0,0,0,0,0,0,1,2'b01,0,0,0);
        v_mem_e   = ov(0,0,0,0,0,0,0,0,1,2'b01,0,0,0);
        v_ld_m    = ov(1,0,1,0,0,0,0,0,0,2'b00,0,0,0);
        v_st_m    = ov(1,1,1,0,0,0,0,0,0,2'b00,0,0,0);
        v_wb_alu  = ov(0,0,0,0,0,1,0,0,0,2'b00,0,0,0);
        v_wb_ld   = ov(0,0,0,0,0,1,0,0,0,2'b00,0,1,0);
        v_br_fail = ov(0,0,0,0,0,0,0,1,0,2'b01,1,0,0);
        v_br_pass = ov(0,0,0,0,1,0,0,1,0,2'b01,1,0,0);
        v_ill     = ov(0,0,0,0,0,0,0,0,0,2'b00,0,0,1);

        rst_n = 1'b0; instr = 32'h0; zflag = 1'b0; mem_ready = 1'b1;

        // Reset held for three cycles with mem_ready high: everything quiet
        step("rst0", S_F, v_zero);
        step("rst1", S_F, v_zero);
        step("rst2", S_F, v_zero);
`ifdef MCTRL_PERF_EN
        chk("rst.cycle_cnt",   cycle_cnt,   32'd0);
        chk("rst.retired_cnt", retired_cnt, 32'd0);
`endif

        // Release: fetch request in the first cycle, stalled one cycle
        rst_n = 1'b1; mem_ready = 1'b0; instr = 32'hE2000005;
        step("rel_f", S_F, v_f0);

        // DP immediate, zero-wait: F D E W
        mem_ready = 1'b1;
        step("dp_f", S_F, v_f1);
        step("dp_d", S_D, v_zero);
        step("dp_e", S_E, v_dp_e);
        step("dp_w", S_W, v_wb_alu);
`ifdef MCTRL_PERF_EN
        chk("dp.cycle_cnt",   cycle_cnt,   32'd5);
        chk("dp.retired_cnt", retired_cnt, 32'd1);
`endif

        // Failed-condition DP (EQ with Z clear): F D E, no writes
        instr = 32'h02000005; zflag = 1'b0;
        step("dpf_f", S_F, v_f1);
        step("dpf_d", S_D, v_zero);
        step("dpf_e", S_E, v_dp_fail);

        // Load with two memory wait cycles: F D E M M M W
        instr = 32'hE5900004;
        step("ld_f", S_F, v_f1);
        step("ld_d", S_D, v_zero);
        mem_ready = 1'b0;
        step("ld_e", S_E, v_mem_e);
        step("ld_m0", S_M, v_ld_m);
        step("ld_m1", S_M, v_ld_m);
        mem_ready = 1'b1;
        step("ld_m2", S_M, v_ld_m);
        step("ld_w", S_W, v_wb_ld);

        // Zero-wait store: F D E M
        instr = 32'hE5800004;
        step("st_f", S_F, v_f1);
        step("st_d", S_D, v_zero);
        step("st_e", S_E, v_mem_e);
        step("st_m", S_M, v_st_m);

        // Branch EQ not taken
        instr = 32'h0A000003; zflag = 1'b0;
        step("brn_f", S_F, v_f1);
        step("brn_d", S_D, v_zero);
        step("brn_e", S_E, v_br_fail);

        // Branch EQ taken
        zflag = 1'b1;
        step("brt_f", S_F, v_f1);
        step("brt_d", S_D, v_zero);
        step("brt_e", S_E, v_br_pass);

        // Reserved op: single illegal pulse, then straight back to fetch
        instr = 32'hEC000000; zflag = 1'b0;
        step("ill_f", S_F, v_f1);
        step("ill_d", S_D, v_zero);
        step("ill_e", S_E, v_ill);
        mem_ready = 1'b0;
        step("ill_ret", S_F, v_f0);

        // Stalled store interrupted by reset
        instr = 32'hE5800004; mem_ready = 1'b1;
        step("rs_f", S_F, v_f1);
        mem_ready = 1'b0;
        step("rs_d", S_D, v_zero);
        step("rs_e", S_E, v_mem_e);
        step("rs_m0", S_M, v_st_m);
        step("rs_m1", S_M, v_st_m);
        rst_n = 1'b0;
        step("rs_rst0", S_F, v_zero);
        step("rs_rst1", S_F, v_zero);
`ifdef MCTRL_PERF_EN
        chk("rs.cycle_cnt",   cycle_cnt,   32'd0);
        chk("rs.retired_cnt", retired_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        step("rs_rel0", S_F, v_f0);
        step("rs_rel1", S_F, v_f0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
